multicycle_control: RTL and testbench

- Moore FSM control unit for the multicycle ARM-subset processor.
- Sequences fetch, decode, execute and writeback over the shared ALU, memory port, register file and immediate extender.
- Drives the extender's 2-bit immediate select and all datapath mux selects and write enables.
- Holds the architectural NZCV flags and evaluates the condition field once per instruction.

---
 rtl/multicycle_control.sv | 205 ++++++++++++++++++++
 tb/tb_multicycle_control.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Moore control FSM for the multicycle ARM-subset core: sequences fetch/decode/execute/
// writeback, owns the NZCV register and latches the condition result once per instruction.
module multicycle_control #(
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] cond,
  input  logic [1:0] op,
  input  logic [5:0] funct,
  input  logic [3:0] rd,
  input  logic [3:0] alu_flags,
  output logic       ir_write,
  output logic       pc_write,
  output logic       mem_write,
  output logic       reg_write,
  output logic       adr_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] imm_src,
  output logic [1:0] alu_control,
  output logic [1:0] result_src,
  output logic [3:0] flags,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,  FETCH  = 4'd1,  DECODE = 4'd2,  MEMADR = 4'd3,
    MEMRD  = 4'd4,  MEMWB  = 4'd5,  MEMWR  = 4'd6,  EXECR  = 4'd7,
    EXECI  = 4'd8,  ALUWB  = 4'd9,  BRANCH = 4'd10
  } state_t;

  state_t     state_r, state_s;
  logic       cond_ex_r, cond_ex_s, cond_pass_s;
  logic [3:0] flags_r, flags_s;
  logic [1:0] alu_dec_s;
  logic       cmp_s, s_bit_s, rd15_s;
  logic       ir_write_s, pc_write_s, mem_write_s, reg_write_s, adr_src_s, alu_src_a_s;
  logic [1:0] alu_src_b_s, imm_src_s, alu_control_s, result_src_s;

  // Flag bits are ordered {N, Z, C, V}.
  function automatic logic cond_check(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, res;
    {n, z, cy, v} = f;
    case (c)
      4'b0000: res = z;
      4'b0001: res = ~z;
      4'b0010: res = cy;
      4'b0011: res = ~cy;
      4'b0100: res = n;
      4'b0101: res = ~n;
      4'b0110: res = v;
      4'b0111: res = ~v;
      4'b1000: res = cy & ~z;
      4'b1001: res = ~cy | z;
      4'b1010: res = (n == v);
      4'b1011: res = (n != v);
      4'b1100: res = ~z & (n == v);
      4'b1101: res = z | (n != v);
      4'b1110: res = 1'b1;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  // ALU command decode; CMP subtracts and always updates flags.
  always_comb begin
    alu_dec_s = 2'b00;
    cmp_s     = 1'b0;
    case (funct[4:1])
      4'b0100: alu_dec_s = 2'b00;
      4'b0010: alu_dec_s = 2'b01;
      4'b0000: alu_dec_s = 2'b10;
      4'b1100: alu_dec_s = 2'b11;
      4'b1010: begin
        alu_dec_s = 2'b01;
        cmp_s     = 1'b1;
      end
      default: alu_dec_s = 2'b00;
    endcase
    s_bit_s     = funct[0] | cmp_s;
    rd15_s      = (rd == 4'd15);
    cond_pass_s = cond_check(cond, flags_r);
  end

  // Next state, latched condition result and flag register update.
  always_comb begin
    state_s   = state_r;
    cond_ex_s = cond_ex_r;
    flags_s   = flags_r;
    case (state_r)
      IDLE:   state_s = FETCH;
      FETCH:  state_s = DECODE;
      DECODE: begin
        cond_ex_s = cond_pass_s;
        case (op)
          2'b01: state_s = MEMADR;
          2'b00: begin
            if (funct[5]) state_s = EXECI;
            else          state_s = EXECR;
          end
          2'b10:   state_s = BRANCH;
          default: state_s = FETCH;
        endcase
      end
      MEMADR: begin
        if (funct[0]) state_s = MEMRD;
        else          state_s = MEMWR;
      end
      MEMRD:  state_s = MEMWB;
      EXECR, EXECI: begin
        state_s = ALUWB;
        if (cond_ex_r && s_bit_s) flags_s = alu_flags;
        else                      flags_s = flags_r;
      end
      MEMWB, MEMWR, ALUWB, BRANCH: state_s = FETCH;
      default: state_s = IDLE;
    endcase
  end

  // Control word for the state being entered, so the outputs come straight from flops.
  always_comb begin
    ir_write_s    = 1'b0;
    pc_write_s    = 1'b0;
    mem_write_s   = 1'b0;
    reg_write_s   = 1'b0;
    adr_src_s     = 1'b0;
    alu_src_a_s   = 1'b0;
    alu_src_b_s   = 2'b00;
    imm_src_s     = 2'b00;
    alu_control_s = 2'b00;
    result_src_s  = 2'b00;
    case (state_s)
      FETCH: begin
        alu_src_a_s = 1'b1;   alu_src_b_s = 2'b10; result_src_s = 2'b10;
        ir_write_s  = 1'b1;   pc_write_s  = 1'b1;
      end
      DECODE: begin
        alu_src_a_s = 1'b1;   alu_src_b_s = 2'b10; result_src_s = 2'b10;
      end
      MEMADR: begin
        alu_src_b_s = 2'b01;  imm_src_s   = 2'b01;
      end
      MEMRD:  adr_src_s = 1'b1;
      MEMWB: begin
        result_src_s = 2'b01;
        reg_write_s  = cond_ex_s;
        pc_write_s   = cond_ex_s & rd15_s;
      end
      MEMWR: begin
        adr_src_s   = 1'b1;
        mem_write_s = cond_ex_s;
      end
      EXECR:  alu_control_s = alu_dec_s;
      EXECI: begin
        alu_src_b_s = 2'b01;  alu_control_s = alu_dec_s;
      end
      ALUWB: begin
        reg_write_s = cond_ex_s & ~cmp_s;
        pc_write_s  = cond_ex_s & ~cmp_s & rd15_s;
      end
      BRANCH: begin
        alu_src_b_s = 2'b01;  imm_src_s = 2'b10; result_src_s = 2'b10;
        pc_write_s  = cond_ex_s;
      end
      default: ir_write_s = 1'b0;
    endcase
  end

  // State, condition latch and NZCV register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      cond_ex_r <= 1'b0;
      flags_r   <= RESET_FLAGS;
    end else begin
      state_r   <= state_s;
      cond_ex_r <= cond_ex_s;
      flags_r   <= flags_s;
    end
  end

  // Registered control outputs; reset clears every enable immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {ir_write, pc_write, mem_write, reg_write, adr_src, alu_src_a} <= 6'b000000;
      {alu_src_b, imm_src, alu_control, result_src}                   <= 8'h00;
    end else begin
      ir_write    <= ir_write_s;
      pc_write    <= pc_write_s;
      mem_write   <= mem_write_s;
      reg_write   <= reg_write_s;
      adr_src     <= adr_src_s;
      alu_src_a   <= alu_src_a_s;
      alu_src_b   <= alu_src_b_s;
      imm_src     <= imm_src_s;
      alu_control <= alu_control_s;
      result_src  <= result_src_s;
    end
  end

  assign flags   = flags_r;
  assign state_o = state_r;

endmodule

// File: tb/tb_multicycle_control.sv
// Table-driven bench for multicycle_control: per-cycle {inputs, expected outputs} records
// go through a scoreboard queue, plus a hand-written mid-instruction reset sequence.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] cond, rd, alu_flags, flags, state_o;
  logic [1:0] op, alu_src_b, imm_src, alu_control, result_src;
  logic [5:0] funct;
  logic       ir_write, pc_write, mem_write, reg_write, adr_src, alu_src_a;
  logic [13:0] act_ctrl;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [3:0]  cond;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  rd;
    logic [3:0]  af;
    logic [3:0]  st;
    logic [13:0] ctrl;
    logic [3:0]  fl;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  logic [3:0] c_cond, c_rd;
  logic [1:0] c_op;
  logic [5:0] c_funct;

  multicycle_control #(.RESET_FLAGS(4'b0000)) dut (
    .clk(clk), .rst_n(rst_n), .cond(cond), .op(op), .funct(funct), .rd(rd),
    .alu_flags(alu_flags), .ir_write(ir_write), .pc_write(pc_write),
    .mem_write(mem_write), .reg_write(reg_write), .adr_src(adr_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src),
    .alu_control(alu_control), .result_src(result_src), .flags(flags),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  assign act_ctrl = {ir_write, pc_write, mem_write, reg_write, adr_src, alu_src_a,
                     alu_src_b, imm_src, alu_control, result_src};

  function automatic logic [13:0] mk(int ir, int pc, int mw, int rw, int adr, int asa,
                                     int asb, int imm, int aluc, int res);
    logic [13:0] v;
    v = {ir[0], pc[0], mw[0], rw[0], adr[0], asa[0], asb[1:0], imm[1:0], aluc[1:0], res[1:0]};
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [13:0] act,
                     input logic [13:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d got=%h expected=%h", name, idx, act, exp);
    end
  endtask

  task automatic instr(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                       input logic [3:0] r);
    c_cond = c; c_op = o; c_funct = f; c_rd = r;
  endtask

  task automatic add(input logic [3:0] af, input logic [3:0] st, input logic [13:0] ctrl,
                     input logic [3:0] fl);
    vec_t v;
    v.cond = c_cond; v.op = c_op; v.funct = c_funct; v.rd = c_rd;
    v.af = af; v.st = st; v.ctrl = ctrl; v.fl = fl;
    vecs.push_back(v);
  endtask

  logic [13:0] cf, cd, z14;
  vec_t e;

  initial begin
    cf  = mk(1, 1, 0, 0, 0, 1, 2, 0, 0, 2);
    cd  = mk(0, 0, 0, 0, 0, 1, 2, 0, 0, 2);
    z14 = 14'h0000;

    // Each record: inputs applied now; state/controls/flags expected after the next edge.
    instr(4'hE, 2'b00, 6'b101000, 4'd3);                           // ADD imm
    add(4'h0, 4'd1, cf, 4'h0);
    add(4'h0, 4'd2, cd, 4'h0);
    add(4'h0, 4'd8, mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0), 4'h0);
    add(4'hF, 4'd9, mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0), 4'h0);        // S=0: flags hold
    add(4'h0, 4'd1, cf, 4'h0);
    instr(4'hE, 2'b00, 6'b000101, 4'd2);                           // SUBS reg
    add(4'h0, 4'd2, cd, 4'h0);
    add(4'h0, 4'd7, mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0), 4'h0);
    add(4'h4, 4'd9, mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0), 4'h4);
    add(4'h0, 4'd1, cf, 4'h4);
    instr(4'h0, 2'b10, 6'b000000, 4'd0);                           // BEQ taken
    add(4'h0, 4'd2, cd, 4'h4);
    add(4'h0, 4'd10, mk(0, 1, 0, 0, 0, 0, 1, 2, 0, 2), 4'h4);
    add(4'h0, 4'd1, cf, 4'h4);
    instr(4'h1, 2'b10, 6'b000000, 4'd0);                           // BNE not taken
    add(4'h0, 4'd2, cd, 4'h4);
    add(4'h0, 4'd10, mk(0, 0, 0, 0, 0, 0, 1, 2, 0, 2), 4'h4);
    add(4'h0, 4'd1, cf, 4'h4);
    instr(4'hE, 2'b01, 6'b011001, 4'd15);                          // LDR pc
    add(4'h0, 4'd2, cd, 4'h4);
    add(4'h0, 4'd3, mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0), 4'h4);
    add(4'h0, 4'd4, mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0), 4'h4);
    add(4'h0, 4'd5, mk(0, 1, 0, 1, 0, 0, 0, 0, 0, 1), 4'h4);
    add(4'h0, 4'd1, cf, 4'h4);
    instr(4'h1, 2'b01, 6'b011000, 4'd4);                           // STRNE, Z=1
    add(4'h0, 4'd2, cd, 4'h4);
    add(4'h0, 4'd3, mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0), 4'h4);
    add(4'h0, 4'd6, mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0), 4'h4);
    add(4'hB, 4'd1, cf, 4'h4);
    instr(4'hE, 2'b11, 6'b000000, 4'd0);                           // unsupported op
    add(4'h0, 4'd2, cd, 4'h4);
    add(4'h0, 4'd1, cf, 4'h4);
    instr(4'hE, 2'b00, 6'b010100, 4'd0);                           // CMP, S forced
    add(4'h0, 4'd2, cd, 4'h4);
    add(4'h0, 4'd7, mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0), 4'h4);
    add(4'h2, 4'd9, z14, 4'h2);
    add(4'h0, 4'd1, cf, 4'h2);
    instr(4'h1, 2'b00, 6'b000101, 4'd6);                           // SUBSNE sets Z itself
    add(4'h0, 4'd2, cd, 4'h2);
    add(4'h0, 4'd7, mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0), 4'h2);
    add(4'h4, 4'd9, mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0), 4'h4);        // latched pass holds
    add(4'h0, 4'd1, cf, 4'h4);
    instr(4'h1, 2'b00, 6'b010100, 4'd0);                           // CMPNE fails
    add(4'h0, 4'd2, cd, 4'h4);
    add(4'h0, 4'd7, mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0), 4'h4);
    add(4'h0, 4'd9, z14, 4'h4);
    add(4'h0, 4'd1, cf, 4'h4);
    instr(4'hE, 2'b00, 6'b011001, 4'd15);                          // ORRS pc
    add(4'h0, 4'd2, cd, 4'h4);
    add(4'h0, 4'd7, mk(0, 0, 0, 0, 0, 0, 0, 0, 3, 0), 4'h4);
    add(4'h9, 4'd9, mk(0, 1, 0, 1, 0, 0, 0, 0, 0, 0), 4'h9);
    add(4'h0, 4'd1, cf, 4'h9);
    instr(4'hA, 2'b00, 6'b100001, 4'd1);                           // ANDSGE imm, N==V
    add(4'h0, 4'd2, cd, 4'h9);
    add(4'h0, 4'd8, mk(0, 0, 0, 0, 0, 0, 1, 0, 2, 0), 4'h9);
    add(4'h6, 4'd9, mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0), 4'h6);
    add(4'h0, 4'd1, cf, 4'h6);
    instr(4'hF, 2'b00, 6'b000011, 4'd15);                          // undecoded cmd, never
    add(4'h0, 4'd2, cd, 4'h6);
    add(4'h0, 4'd7, z14, 4'h6);
    add(4'h1, 4'd9, z14, 4'h6);
    add(4'h0, 4'd1, cf, 4'h6);
    instr(4'hE, 2'b01, 6'b011000, 4'd4);                           // STR AL, reset in MEMWR
    add(4'h0, 4'd2, cd, 4'h6);
    add(4'h0, 4'd3, mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0), 4'h6);
    add(4'h0, 4'd6, mk(0, 0, 1, 0, 1, 0, 0, 0, 0, 0), 4'h6);

    rst_n = 1'b0; cond = 4'h0; op = 2'b00; funct = 6'h00; rd = 4'h0; alu_flags = 4'h0;
    repeat (2) @(negedge clk);
    chk("reset_state", 0, {10'h000, state_o}, 14'h0000);
    chk("reset_ctrl", 0, act_ctrl, z14);
    chk("reset_flags", 0, {10'h000, flags}, 14'h0000);
    rst_n = 1'b1;
    #1;
    chk("idle_ctrl", 0, act_ctrl, z14);
    chk("idle_state", 0, {10'h000, state_o}, 14'h0000);

    for (int i = 0; i < vecs.size(); i++) begin
      cond = vecs[i].cond; op = vecs[i].op; funct = vecs[i].funct;
      rd = vecs[i].rd; alu_flags = vecs[i].af;
      exp_q.push_back(vecs[i]);
      @(posedge clk);
      @(negedge clk);
      e = exp_q.pop_front();
      chk("state", i + 1, {10'h000, state_o}, {10'h000, e.st});
      chk("ctrl", i + 1, act_ctrl, e.ctrl);
      chk("flags", i + 1, {10'h000, flags}, {10'h000, e.fl});
    end

    // Asynchronous reset while the store strobe is high.
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mem_write", 0, {13'h0000, mem_write}, 14'h0000);
    chk("rst_ctrl", 0, act_ctrl, z14);
    chk("rst_state", 0, {10'h000, state_o}, 14'h0000);
    chk("rst_flags", 0, {10'h000, flags}, 14'h0000);
    @(negedge clk);
    chk("rst_hold_state", 0, {10'h000, state_o}, 14'h0000);
    rst_n = 1'b1;
    @(negedge clk);
    chk("refetch_state", 0, {10'h000, state_o}, 14'h0001);
    chk("refetch_ctrl", 0, act_ctrl, cf);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
